// File: rtl/bitstream_scheduler.sv
// Multi-lane scheduler: converts signed QUANT-bit samples into thermometer-coded
// stochastic bitstreams of BITSTREAM beats, with a one-entry pending buffer.
module bitstream_scheduler #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*QUANT-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_bits,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   busy
);

    localparam int KW = $clog2(BITSTREAM);
    localparam int QW = KW + 1;
    localparam int D  = QUANT - KW;
    localparam int RND_SHIFT = (D > 0) ? D - 1 : 0;
    localparam logic [QUANT:0]   RND      = (D > 0) ? ((QUANT+1)'(1) << RND_SHIFT) : '0;
    localparam logic [QUANT-1:0] SIGN_BIT = QUANT'(1) << (QUANT - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(BITSTREAM - 1);

    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
        $error("BITSTREAM must be a power of two >= 2");
    end
    if (QUANT < KW) begin : g_bad_quant
        $error("QUANT must be >= $clog2(BITSTREAM)");
    end

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic            pend_valid;
    logic [QW-1:0]   act_q  [LANES];
    logic [QW-1:0]   pend_q [LANES];
    logic [QW-1:0]   in_quota [LANES];

    logic fire, last_fire, accept;
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && (k == K_LAST);
    assign accept    = in_valid && in_ready;

    // Flipping the sign bit adds 2^(QUANT-1); the extra MSB keeps the rounding
    // carry so the top code reaches exactly BITSTREAM instead of wrapping.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [QUANT:0] biased;
        logic [QUANT:0] rounded;
        assign biased      = {1'b0, in_data[i*QUANT +: QUANT] ^ SIGN_BIT};
        assign rounded     = biased + RND;
        assign in_quota[i] = QW'(rounded >> D);
        assign out_bits[i] = out_valid && ({1'b0, k} < act_q[i]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = STREAM;
            STREAM:  if (last_fire && !pend_valid && !in_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == STREAM);
        out_first = out_valid && (k == '0);
        out_last  = out_valid && (k == K_LAST);
        busy      = (state == STREAM) || pend_valid;
        in_ready  = !pend_valid;
    end

    // NOTE: the quota arrays are small register sets, so they are cleared on
    // reset like the rest of the state rather than left undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            pend_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                act_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else if (state == IDLE) begin
            if (in_valid) begin
                act_q <= in_quota;
                k     <= '0;
            end
        end else begin
            if (last_fire) begin
                k <= '0;
                if (pend_valid) begin
                    act_q      <= pend_q;
                    pend_valid <= 1'b0;
                end else if (in_valid) begin
                    act_q <= in_quota;
                end
            end else if (fire) begin
                k <= k + KW'(1);
            end
            // On the last beat an accepted input bypasses into active instead.
            if (accept && !last_fire) begin
                pend_q     <= in_quota;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_scheduler.sv
// Self-checking bench for bitstream_scheduler: a frame-level scoreboard fed on
// input acceptance and drained on every accepted output beat.
module tb_bitstream_scheduler;

    localparam int BS = 64;
    localparam int QN = 8;
    localparam int LN = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [LN*QN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [LN-1:0]   out_bits;
    logic            out_first;
    logic            out_last;
    logic            busy;

    bitstream_scheduler #(.BITSTREAM(BS), .QUANT(QN), .LANES(LN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [LN-1:0] bits;
        logic          first;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_beats, n_first, n_last;
    int    ones[LN];
    logic  in_acc;
    logic  held;
    beat_t held_beat;

    function automatic logic [LN*QN-1:0] pack(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    // Reference quota: round((x + 128) / 4) with ties up, no saturation needed.
    function automatic int model_quota(input logic signed [QN-1:0] x);
        return (int'(x) + 128 + 2) / 4;
    endfunction

    task automatic push_frame(input logic [LN*QN-1:0] v);
        int    q[LN];
        beat_t b;
        for (int i = 0; i < LN; i++) q[i] = model_quota(v[i*QN +: QN]);
        for (int kk = 0; kk < BS; kk++) begin
            for (int i = 0; i < LN; i++) b.bits[i] = (kk < q[i]);
            b.first = (kk == 0);
            b.last  = (kk == BS - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_counts();
        n_beats = 0; n_first = 0; n_last = 0;
        for (int i = 0; i < LN; i++) ones[i] = 0;
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        beat_t cur, e;
        @(negedge clk);
        in_acc = 1'b0;
        cur = {out_bits, out_first, out_last};
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || cur !== held_beat) begin
                    n_err++;
                    $display("FAIL hold_stable: got valid=%b beat=%b, required valid=1 beat=%b", out_valid, cur, held_beat);
                end
            end
            if (in_valid && in_ready) begin
                in_acc = 1'b1;
                push_frame(in_data);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got beat=%b, required none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_err++;
                        $display("FAIL beat: got bits=%b first=%b last=%b, required bits=%b first=%b last=%b",
                                 cur.bits, cur.first, cur.last, e.bits, e.first, e.last);
                    end
                end
                n_beats++;
                n_first += int'(out_first);
                n_last  += int'(out_last);
                for (int i = 0; i < LN; i++) ones[i] += int'(out_bits[i]);
            end
            held      = out_valid && !out_ready;
            held_beat = cur;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [LN*QN-1:0] v);
        int w = 0;
        in_valid = 1'b1;
        in_data  = v;
        do begin
            cycle();
            w++;
        end while (!in_acc && w < 300);
        in_valid = 1'b0;
        n_cmp++;
        if (!in_acc) begin
            n_err++;
            $display("FAIL send_timeout: got no acceptance in %0d cycles, required acceptance", w);
        end
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && w < 600) begin
            cycle();
            w++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_idle: got valid=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic check_ones(input string name, input int e0, input int e1, input int e2, input int e3);
        int e[LN];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < LN; i++) begin
            n_cmp++;
            if (ones[i] !== e[i]) begin
                n_err++;
                $display("FAIL %s_ones_lane%0d: got %0d, required %0d", name, i, ones[i], e[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        held = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, out_bits, out_first, out_last, busy, in_ready} !== {1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values: got v=%b bits=%b f=%b l=%b busy=%b rdy=%b, required 0 0000 0 0 0 1",
                     out_valid, out_bits, out_first, out_last, busy, in_ready);
        end
    endtask

    task automatic test_conversion();
        clear_counts();
        out_ready = 1'b1;
        send(pack(-128, 0, 2, 127));
        n_cmp++;
        if (out_valid !== 1'b1 || out_first !== 1'b1) begin
            n_err++;
            $display("FAIL conv_latency: got valid=%b first=%b, required 1 1", out_valid, out_first);
        end
        drain();
        check_ones("conv", 0, 32, 33, 64);
        n_cmp++;
        if (n_beats !== BS) begin
            n_err++;
            $display("FAIL conv_beats: got %0d, required %0d", n_beats, BS);
        end
    endtask

    task automatic test_rounding();
        clear_counts();
        send(pack(-3, 1, -1, 126));
        drain();
        check_ones("round", 31, 32, 32, 64);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(pack(-128, 0, 2, 127));
        send(pack(-3, 1, -1, 126));
        for (int i = 0; i < 2*BS - 1; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== (i >= BS - 1)) begin
                n_err++;
                $display("FAIL b2b_beat%0d: got valid=%b rdy=%b, required valid=1 rdy=%b", i, out_valid, in_ready, i >= BS - 1);
            end
            cycle();
        end
        drain();
    endtask

    task automatic test_pending_full();
        clear_counts();
        out_ready = 1'b1;
        send(pack(-128, 0, 2, 127));
        send(pack(-3, 1, -1, 126));
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pend_full: got rdy=%b busy=%b, required 0 1", in_ready, busy);
        end
        send(pack(-64, 64, -100, 100));
        n_cmp++;
        if (n_beats !== BS + 1) begin
            n_err++;
            $display("FAIL pend_swap_point: got third accepted after %0d beats, required %0d", n_beats, BS + 1);
        end
        drain();
        check_ones("pend", 0 + 31 + 16, 32 + 32 + 48, 33 + 32 + 7, 64 + 64 + 57);
    endtask

    task automatic test_backpressure();
        int w = 0;
        clear_counts();
        out_ready = 1'b1;
        send(pack(-64, 64, -100, 100));
        while (exp_q.size() != 0 && w < 1000) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            w++;
        end
        drain();
        n_cmp++;
        if (n_beats !== BS || n_first !== 1 || n_last !== 1) begin
            n_err++;
            $display("FAIL bp_counts: got beats=%0d first=%0d last=%0d, required %0d 1 1", n_beats, n_first, n_last, BS);
        end
        check_ones("bp", 16, 48, 7, 57);
    endtask

    task automatic test_reset_mid();
        clear_counts();
        out_ready = 1'b1;
        send(pack(-128, 0, 2, 127));
        send(pack(-3, 1, -1, 126));
        repeat (19) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_bits !== 4'b0) begin
            n_err++;
            $display("FAIL midreset: got v=%b busy=%b rdy=%b bits=%b, required 0 0 1 0000", out_valid, busy, in_ready, out_bits);
        end
        clear_counts();
        send(pack(-64, 64, -100, 100));
        n_cmp++;
        if (out_first !== 1'b1 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_restart: got first=%b last=%b, required 1 0", out_first, out_last);
        end
        drain();
        check_ones("midreset", 16, 48, 7, 57);
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_rounding();
        test_back_to_back();
        test_pending_full();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bitstream_scheduler.md
# bitstream_scheduler

Multi-lane controller that turns vectors of signed QUANT-bit values into thermometer-coded stochastic bitstreams of BITSTREAM beats. It sits between the quantized-data producer and the stochastic-computing arithmetic array. Per lane, it performs the bias/round quota conversion. It sequences each frame over BITSTREAM output beats with valid/ready flow control. A one-entry pending buffer allows back-to-back frames with no bubble.

## Interface
- BITSTREAM, 64, beats per frame; must be a power of two (elaboration error otherwise)
- QUANT, 8, input sample width; QUANT >= $clog2(BITSTREAM) (elaboration error otherwise)
- LANES, 4, values per input vector / bits per output beat
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input vector valid
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  LANES*QUANT  lane i = in_data[i*QUANT +: QUANT], signed two's complement
- out_valid  output  1  out_bits holds a valid beat
- out_ready  input  1  downstream accepts beat
- out_bits  output  LANES  bit i = lane i stochastic bit for current beat
- out_first  output  1  current beat is beat 0 of frame
- out_last  output  1  current beat is beat BITSTREAM-1 of frame
- busy  output  1  frame active or pending

## Operation
- Quota per lane, computed at input acceptance from in_data. QW = $clog2(BITSTREAM) + 1 bits. D = QUANT - $clog2(BITSTREAM).
  - bias = data + 2^(QUANT-1), unsigned, QUANT+1 bits; range 0..2^QUANT-1
  - round = bias + 2^(D-1); the rounding term is 0 when D == 0
  - quota = round >> D, kept at QW bits; range 0..BITSTREAM inclusive; no wrap, so max positive input gives all-ones
- Beat k of a frame (k = 0..BITSTREAM-1): out_bits[i] = (k < quota_i), a thermometer code. Lane i emits exactly quota_i ones per frame.
- Registers:
  - active quota set plus beat counter k, $clog2(BITSTREAM) bits
  - pending quota set plus pend_valid
  - state IDLE or STREAM
- in_ready = !pend_valid. It is registered-state only; there is no combinational path from out_ready.
- IDLE:
  - out_valid = 0
  - on in_valid, the vector's quotas load into active, k = 0, and next state is STREAM
- STREAM:
  - out_valid = 1
  - on each out_valid && out_ready, k increments
  - an input accepted while streaming loads pending, unless bypassed (see below)
- Last beat accepted (k == BITSTREAM-1 && out_ready):
  - if pend_valid: pending moves to active, k = 0, pend_valid clears, stay in STREAM with no bubble
  - else if in_valid in the same cycle: bypass the input directly into active, k = 0, stay in STREAM
  - else: go to IDLE, k = 0
- Pending is full and an input is offered: in_ready = 0 and the input is held off; no overwrite ever occurs.
- out_first = (k == 0) && out_valid. out_last = (k == BITSTREAM-1) && out_valid.
- busy = (state == STREAM) || pend_valid.
- Backpressure: while out_ready = 0, k, out_bits, out_first and out_last hold stable.

## Timing
- Reset values:
  - state IDLE, k = 0, pend_valid = 0
  - active and pending quotas = 0
  - out_valid = 0, out_bits = 0, out_first = 0, out_last = 0, busy = 0, in_ready = 1
- Reset mid-frame: the frame and pending are discarded; the next cycle shows the reset values.
- Latency: a vector accepted in IDLE at edge T presents beat 0 after T, i.e. 1 cycle.
- Frame length: exactly BITSTREAM accepted beats.
- Back-to-back: the cycle after the last beat of frame n is accepted shows beat 0 of frame n+1 when pending is valid or the input was bypassed.
- All outputs come from registers plus a comparator on active quota vs k. No input-to-output combinational path.

## Test plan
- Conversion, QUANT=8, BITSTREAM=64, LANES=4: in_data lanes {-128, 0, 2, 127} -> quotas {0, 32, 33, 64}; over 64 beats lane0 stays all-zero, lane1 is 1 for k<32, lane2 for k<33, lane3 is high all 64 beats.
- Rounding: lanes {-3, 1, -1, 126} -> quotas {31, 32, 32, 64}; count ones per lane over the frame.
- Back-to-back: a second vector is accepted during frame 1, and in_ready drops until the swap. Required: out_last on beat 63 is followed the next cycle by out_first with the new quotas; 128 consecutive valid beats with no bubble.
- Pending full: a third vector is held with in_valid = 1 while pending is full. Required: in_ready = 0 until the frame-1 swap; all three frames are emitted in order with no loss or duplication.
- Backpressure: out_ready toggles randomly with a 50% duty. Required: held beats stay stable, the frame still has exactly 64 accepted beats, and out_first/out_last each occur once.
- Reset mid-frame: assert rst at beat 20 with pending valid. Required: the next cycle shows out_valid = 0, busy = 0, in_ready = 1; a new vector then starts a clean frame at k = 0.
